// File: rtl/ico_servo_ramp.sv
// Servo ramp controller: SPI-loaded per-channel target/step registers and a
// once-per-frame scan that slews each channel toward its target, emitting PWM config writes.
module ico_servo_ramp #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned FRAME_CYCLES = 240000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_ctrl_si,
  input  logic        spi_ctrl_hd,
  input  logic [7:0]  spi_ctrl_di,
  output logic [7:0]  spi_ctrl_do,
  input  logic [1:0]  epsel,
  output logic        cfg_we,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  output logic        frame_tick
);

  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {SPI_CMD, SPI_TGT, SPI_STP} spi_state_e;
  typedef enum logic [1:0] {SC_IDLE, SC_SCAN, SC_DONE} scan_state_e;

  logic [7:0] tgt_q [NUM_CH];
  logic [7:0] stp_q [NUM_CH];
  logic [7:0] cur_q [NUM_CH];

  // SPI endpoint FSM
  spi_state_e spi_q, spi_d;
  logic [7:0] waddr_q, waddr_d;
  logic       tgt_we_c, stp_we_c;

  always_comb begin
    spi_d    = spi_q;
    waddr_d  = waddr_q;
    tgt_we_c = 1'b0;
    stp_we_c = 1'b0;
    unique case (spi_q)
      SPI_CMD: begin
        if (spi_ctrl_hd && spi_ctrl_si) begin
          waddr_d = spi_ctrl_di;
          if (epsel[1])      spi_d = SPI_STP;
          else if (epsel[0]) spi_d = SPI_TGT;
        end
      end
      SPI_TGT: begin
        if (!epsel[0]) begin
          spi_d = SPI_CMD;
        end else if (spi_ctrl_si) begin
          tgt_we_c = (waddr_q < 8'(NUM_CH));
          waddr_d  = waddr_q + 8'd1;
        end
      end
      SPI_STP: begin
        if (!epsel[1]) begin
          spi_d = SPI_CMD;
        end else if (spi_ctrl_si) begin
          stp_we_c = (waddr_q < 8'(NUM_CH));
          waddr_d  = waddr_q + 8'd1;
        end
      end
      default: spi_d = SPI_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spi_q   <= SPI_CMD;
      waddr_q <= '0;
    end else begin
      spi_q   <= spi_d;
      waddr_q <= waddr_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        tgt_q[i] <= '0;
        stp_q[i] <= '0;
      end
    end else begin
      if (tgt_we_c) tgt_q[waddr_q[ChW-1:0]] <= spi_ctrl_di;
      if (stp_we_c) stp_q[waddr_q[ChW-1:0]] <= spi_ctrl_di;
    end
  end

  // Frame counter; the tick register is high while the count sits at 0
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  assign cnt_d = (cnt_q == CntW'(FRAME_CYCLES - 1)) ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign frame_tick = tick_q;

  // Ramp step for the channel under scan: 9-bit sums catch carry/borrow
  logic [ChW-1:0] ch_q, ch_d;
  logic [7:0]     cur_c, tgt_c, stp_c, nxt_c;
  logic [8:0]     up_c, dn_c;

  assign cur_c = cur_q[ch_q];
  assign tgt_c = tgt_q[ch_q];
  assign stp_c = stp_q[ch_q];

  always_comb begin
    up_c = {1'b0, cur_c} + {1'b0, stp_c};
    dn_c = {1'b0, cur_c} - {1'b0, stp_c};
    if (stp_c == 8'd0) begin
      nxt_c = tgt_c;
    end else if (cur_c < tgt_c) begin
      nxt_c = (up_c >= {1'b0, tgt_c}) ? tgt_c : up_c[7:0];
    end else if (dn_c[8] || (dn_c[7:0] <= tgt_c)) begin
      nxt_c = tgt_c;
    end else begin
      nxt_c = dn_c[7:0];
    end
  end

  // Scan FSM
  scan_state_e scan_q, scan_d;
  logic        pend_q, pend_d;
  logic        init_q, init_d;
  logic        cur_we_c;
  logic        cfg_we_q, cfg_we_d;
  logic [7:0]  cfg_addr_q, cfg_addr_d;
  logic [15:0] cfg_wdata_q, cfg_wdata_d;

  always_comb begin
    scan_d      = scan_q;
    ch_d        = ch_q;
    pend_d      = pend_q;
    init_d      = init_q;
    cur_we_c    = 1'b0;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    if (tick_q && (scan_q != SC_IDLE)) pend_d = 1'b1;
    unique case (scan_q)
      SC_IDLE: begin
        if (tick_q || pend_q) begin
          scan_d = SC_SCAN;
          ch_d   = '0;
          pend_d = 1'b0;
        end
      end
      SC_SCAN: begin
        cur_we_c = 1'b1;
        if ((nxt_c != cur_c) || init_q) begin
          cfg_we_d    = 1'b1;
          cfg_addr_d  = 8'(ch_q);
          cfg_wdata_d = {8'(ch_q), nxt_c};
        end
        if (ch_q == ChW'(NUM_CH - 1)) scan_d = SC_DONE;
        else                          ch_d   = ch_q + ChW'(1);
      end
      SC_DONE: begin
        init_d = 1'b0;
        scan_d = SC_IDLE;
      end
      default: scan_d = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_q      <= SC_IDLE;
      ch_q        <= '0;
      pend_q      <= 1'b0;
      init_q      <= 1'b1;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
    end else begin
      scan_q      <= scan_d;
      ch_q        <= ch_d;
      pend_q      <= pend_d;
      init_q      <= init_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_CH); i++) cur_q[i] <= '0;
    end else if (cur_we_c) begin
      cur_q[ch_q] <= nxt_c;
    end
  end

  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;

  // Settled flags for channels 0..7; absent channels report settled
  logic [7:0] settled_c;
  logic [7:0] do_q;

  for (genvar n = 0; n < 8; n++) begin : g_do
    if (n < NUM_CH) begin : g_ch
      assign settled_c[n] = (cur_q[n] == tgt_q[n]);
    end else begin : g_none
      assign settled_c[n] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) do_q <= 8'hFF;
    else         do_q <= settled_c;
  end

  assign spi_ctrl_do = do_q;

endmodule

// File: tb/tb_ico_servo_ramp.sv
// Randomized self-checking bench for ico_servo_ramp against a frame-level
// behavioural model of the target/step/cur registers.
module tb_ico_servo_ramp;

  localparam int unsigned NCH = 8;
  localparam int unsigned FC  = 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spi_ctrl_si, spi_ctrl_hd;
  logic [7:0]  spi_ctrl_di, spi_ctrl_do;
  logic [1:0]  epsel;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        frame_tick;

  ico_servo_ramp #(.NUM_CH(NCH), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .spi_ctrl_si(spi_ctrl_si), .spi_ctrl_hd(spi_ctrl_hd),
    .spi_ctrl_di(spi_ctrl_di), .spi_ctrl_do(spi_ctrl_do),
    .epsel(epsel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_tgt [NCH];
  int m_stp [NCH];
  int m_cur [NCH];
  bit m_init;

  logic [23:0] got_q [$];
  logic [23:0] exp_q [$];

  always @(negedge clk) if (cfg_we) got_q.push_back({cfg_addr, cfg_wdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      m_tgt[i] = 0; m_stp[i] = 0; m_cur[i] = 0;
    end
    m_init = 1'b1;
  endtask

  function automatic int ramp(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t)  return (c + s > t) ? t : c + s;
    return (c - s < t) ? t : c - s;
  endfunction

  task automatic model_frame();
    exp_q.delete();
    for (int i = 0; i < int'(NCH); i++) begin
      int nx;
      nx = ramp(m_cur[i], m_tgt[i], m_stp[i]);
      if (nx != m_cur[i] || m_init) exp_q.push_back({8'(i), 8'(i), 8'(nx)});
      m_cur[i] = nx;
    end
    m_init = 1'b0;
  endtask

  function automatic logic [7:0] model_do();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (i >= int'(NCH)) ? 1'b1 : (m_cur[i] == m_tgt[i]);
    return v;
  endfunction

  task automatic spi_byte(input logic hd, input logic [7:0] d);
    @(negedge clk);
    spi_ctrl_si = 1'b1; spi_ctrl_hd = hd; spi_ctrl_di = d;
    @(negedge clk);
    spi_ctrl_si = 1'b0; spi_ctrl_hd = 1'b0;
  endtask

  // Command byte plus n data bytes on the endpoint(s) selected by sel
  task automatic spi_xfer(input logic [1:0] sel, input logic [7:0] addr,
                          input int n, input logic [7:0] d [4]);
    logic [7:0] a;
    @(negedge clk);
    epsel = sel;
    spi_byte(1'b1, addr);
    a = addr;
    for (int i = 0; i < n; i++) begin
      spi_byte(1'b0, d[i]);
      if (a < 8'(NCH)) begin
        if (sel[1]) m_stp[a] = int'(d[i]);
        else        m_tgt[a] = int'(d[i]);
      end
      a = a + 8'd1;
    end
    @(negedge clk);
    epsel = 2'b00;
    @(negedge clk);
  endtask

  task automatic wait_tick(output bit ok);
    int k;
    k = 0;
    while (frame_tick !== 1'b1 && k < int'(2 * FC)) begin
      @(negedge clk);
      k++;
    end
    ok = (frame_tick === 1'b1);
  endtask

  // One frame: collect writes after the tick and compare with the model
  task automatic run_frame(input string tag, output int nwr);
    bit ok;
    wait_tick(ok);
    check({tag, "_tick"}, 32'(ok), 32'd1);
    got_q.delete();
    model_frame();
    repeat (14) @(negedge clk);
    nwr = got_q.size();
    check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_do"}, 32'(spi_ctrl_do), 32'(model_do()));
  endtask

  initial begin
    logic [7:0] d [4];
    int nwr;
    bit ok;

    resetn = 1'b0; spi_ctrl_si = 1'b0; spi_ctrl_hd = 1'b0;
    spi_ctrl_di = '0; epsel = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_we",    32'(cfg_we),      32'd0);
    check("rst_addr",  32'(cfg_addr),    32'd0);
    check("rst_wdata", 32'(cfg_wdata),   32'd0);
    check("rst_tick",  32'(frame_tick),  32'd0);
    check("rst_do",    32'(spi_ctrl_do), 32'hFF);
    resetn = 1'b1;

    run_frame("init", nwr);
    check("init_cnt", 32'(nwr), 32'd8);
    check("init_w3", 32'(got_q.size() > 3 ? got_q[3] : 24'hx), 32'h030300);
    run_frame("quiet", nwr);
    check("quiet_cnt", 32'(nwr), 32'd0);

    d = '{8'h96, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b01, 8'h02, 1, d);
    run_frame("tgt2", nwr);
    check("tgt2_cnt", 32'(nwr), 32'd1);
    check("tgt2_val", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h020296);
    check("tgt2_do2", 32'(spi_ctrl_do[2]), 32'd1);

    d = '{8'd40, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b10, 8'h03, 1, d);
    d = '{8'd100, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b01, 8'h03, 1, d);
    run_frame("ramp1", nwr);
    check("ramp1_v", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h030328);
    run_frame("ramp2", nwr);
    check("ramp2_v", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h030350);
    run_frame("ramp3", nwr);
    check("ramp3_v", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h030364);
    run_frame("ramp4", nwr);
    check("ramp4_cnt", 32'(nwr), 32'd0);

    d = '{8'd100, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b01, 8'h04, 1, d);
    run_frame("c4up", nwr);
    d = '{8'd200, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b10, 8'h04, 1, d);
    d = '{8'd10, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b01, 8'h04, 1, d);
    run_frame("clamp", nwr);
    check("clamp_cnt", 32'(nwr), 32'd1);
    check("clamp_v", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h04040A);

    d = '{8'd5, 8'd5, 8'h00, 8'h00};
    spi_xfer(2'b11, 8'h07, 2, d);
    check("stp7", 32'(m_stp[7]), 32'd5);
    d = '{8'd50, 8'h00, 8'h00, 8'h00};
    spi_xfer(2'b01, 8'h07, 1, d);
    run_frame("s7a", nwr);
    check("s7a_v", 32'(got_q.size() > 0 ? got_q[0] : 24'hx), 32'h070705);

    for (int f = 0; f < 20; f++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        d[i] = 8'($urandom);
        if (sel[1] && $urandom_range(0, 2) == 0) d[i] = 8'h00;
      end
      spi_xfer(sel, 8'($urandom_range(0, 9)), int'($urandom_range(1, 3)), d);
      run_frame($sformatf("rnd%0d", f), nwr);
    end

    d = '{8'd77, 8'd88, 8'd99, 8'd111};
    spi_xfer(2'b01, 8'h00, 4, d);
    spi_xfer(2'b01, 8'h04, 4, d);
    wait_tick(ok);
    check("mid_tick", 32'(ok), 32'd1);
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("mid_we",   32'(cfg_we),      32'd0);
    check("mid_tk",   32'(frame_tick),  32'd0);
    check("mid_do",   32'(spi_ctrl_do), 32'hFF);
    got_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("post_rst_nowr", 32'(got_q.size()), 32'd0);
    run_frame("rewr", nwr);
    check("rewr_cnt", 32'(nwr), 32'd8);
    check("rewr_w7", 32'(got_q.size() > 7 ? got_q[7] : 24'hx), 32'h070700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
